// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared FSM state encoding and grant IDs for mem_arbiter
package mem_arb_pkg;

    // Arbiter transaction phases
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Requester identifiers used for grant and last_grant
    localparam logic GNT_IFU = 1'b0;
    localparam logic GNT_LSU = 1'b1;

endpackage

// File: rtl/mem_arb_sel.sv
// rtl/mem_arb_sel.sv - combinational winner select; ARB_RR_EN selects round-robin over fixed priority
module mem_arb_sel (
    input  logic ifu_req,
    input  logic lsu_req,
    input  logic last_grant,
    output logic winner
);
    import mem_arb_pkg::*;

`ifdef ARB_RR_EN
    // On a tie the requester that was not served last wins; a lone requester always wins
    always_comb begin
        winner = GNT_IFU;
        if (ifu_req && lsu_req) begin
            winner = (last_grant == GNT_IFU) ? GNT_LSU : GNT_IFU;
        end else if (lsu_req) begin
            winner = GNT_LSU;
        end
    end
`else
    // Fixed priority: history is irrelevant, so last_grant is intentionally left unused
    logic sel_unused;
    assign sel_unused = last_grant;

    // LSU beats IFU whenever it is requesting
    always_comb begin
        winner = GNT_IFU;
        if (lsu_req) begin
            winner = GNT_LSU;
        end else if (ifu_req) begin
            winner = GNT_IFU;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-outstanding IFU/LSU memory port arbiter; ARB_RR_EN enables round-robin
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ifu_reqValid,
    input  logic [ADDR_WIDTH-1:0]   ifu_raddr,
    output logic                    ifu_respValid,
    output logic [DATA_WIDTH-1:0]   ifu_rdata,
    input  logic                    lsu_reqValid,
    input  logic [ADDR_WIDTH-1:0]   lsu_addr,
    input  logic                    lsu_wen,
    input  logic [DATA_WIDTH-1:0]   lsu_wdata,
    input  logic [DATA_WIDTH/8-1:0] lsu_wmask,
    output logic                    lsu_respValid,
    output logic [DATA_WIDTH-1:0]   lsu_rdata,
    output logic                    mem_reqValid,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_wen,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wmask,
    input  logic                    mem_respValid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);
    import mem_arb_pkg::*;

    state_t state;
    logic   grant;
    logic   last_grant;
    logic   sel_winner;

    mem_arb_sel u_sel (
        .ifu_req    (ifu_reqValid),
        .lsu_req    (lsu_reqValid),
        .last_grant (last_grant),
        .winner     (sel_winner)
    );

    // Transaction FSM: grant and latch in IDLE, wait for memory in BUSY, pulse response in RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            grant         <= GNT_IFU;
            last_grant    <= GNT_IFU;
            mem_reqValid  <= 1'b0;
            mem_addr      <= '0;
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
            ifu_respValid <= 1'b0;
            ifu_rdata     <= '0;
            lsu_respValid <= 1'b0;
            lsu_rdata     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // reqValid is only looked at here, so a finished request cannot be re-granted
                    if (ifu_reqValid || lsu_reqValid) begin
                        grant        <= sel_winner;
                        mem_reqValid <= 1'b1;
                        if (sel_winner == GNT_LSU) begin
                            mem_addr  <= lsu_addr;
                            mem_wen   <= lsu_wen;
                            mem_wdata <= lsu_wdata;
                            mem_wmask <= lsu_wmask;
                        end else begin
                            mem_addr  <= ifu_raddr;
                            mem_wen   <= 1'b0;
                            mem_wdata <= '0;
                            mem_wmask <= '0;
                        end
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // Only the granted requester's rdata register is written
                    if (mem_respValid) begin
                        mem_reqValid <= 1'b0;
                        if (grant == GNT_LSU) begin
                            lsu_rdata     <= mem_rdata;
                            lsu_respValid <= 1'b1;
                        end else begin
                            ifu_rdata     <= mem_rdata;
                            ifu_respValid <= 1'b1;
                        end
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    ifu_respValid <= 1'b0;
                    lsu_respValid <= 1'b0;
                    last_grant    <= grant;
                    state         <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with transaction-level reference model
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ifu_reqValid = 1'b0;
    logic [AW-1:0] ifu_raddr = '0;
    logic          ifu_respValid;
    logic [DW-1:0] ifu_rdata;
    logic          lsu_reqValid = 1'b0;
    logic [AW-1:0] lsu_addr = '0;
    logic          lsu_wen = 1'b0;
    logic [DW-1:0] lsu_wdata = '0;
    logic [MW-1:0] lsu_wmask = '0;
    logic          lsu_respValid;
    logic [DW-1:0] lsu_rdata;
    logic          mem_reqValid;
    logic [AW-1:0] mem_addr;
    logic          mem_wen;
    logic [DW-1:0] mem_wdata;
    logic [MW-1:0] mem_wmask;
    logic          mem_respValid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ifu_reqValid  (ifu_reqValid),
        .ifu_raddr     (ifu_raddr),
        .ifu_respValid (ifu_respValid),
        .ifu_rdata     (ifu_rdata),
        .lsu_reqValid  (lsu_reqValid),
        .lsu_addr      (lsu_addr),
        .lsu_wen       (lsu_wen),
        .lsu_wdata     (lsu_wdata),
        .lsu_wmask     (lsu_wmask),
        .lsu_respValid (lsu_respValid),
        .lsu_rdata     (lsu_rdata),
        .mem_reqValid  (mem_reqValid),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_respValid (mem_respValid),
        .mem_rdata     (mem_rdata)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: one pending transaction record plus per-requester read data
    bit            m_act = 0;
    bit            m_done = 0;
    bit            m_who = 0;
    bit            m_last = 0;
    logic [AW-1:0] m_addr = '0;
    logic          m_wen = 1'b0;
    logic [DW-1:0] m_wdata = '0;
    logic [MW-1:0] m_wmask = '0;
    logic [DW-1:0] m_rd [2] = '{default: '0};
    bit            model_on = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act = 0; m_done = 0; m_who = 0; m_last = 0;
            m_addr = '0; m_wen = 1'b0; m_wdata = '0; m_wmask = '0;
            m_rd[0] = '0; m_rd[1] = '0;
        end else if (m_act && m_done) begin
            m_act = 0; m_done = 0; m_last = m_who;
        end else if (m_act) begin
            if (mem_respValid) begin
                m_rd[m_who] = mem_rdata;
                m_done = 1;
            end
        end else if (ifu_reqValid || lsu_reqValid) begin
`ifdef ARB_RR_EN
            m_who = (ifu_reqValid && lsu_reqValid) ? !m_last : lsu_reqValid;
`else
            m_who = lsu_reqValid;
`endif
            m_act = 1;
            if (m_who) begin
                m_addr = lsu_addr; m_wen = lsu_wen; m_wdata = lsu_wdata; m_wmask = lsu_wmask;
            end else begin
                m_addr = ifu_raddr; m_wen = 1'b0; m_wdata = '0; m_wmask = '0;
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("mem_reqValid", mem_reqValid, m_act && !m_done);
            if (m_act && !m_done) begin
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_wen", mem_wen, m_wen);
                chk("mem_wdata", mem_wdata, m_wdata);
                chk("mem_wmask", mem_wmask, m_wmask);
            end
            chk("ifu_respValid", ifu_respValid, m_act && m_done && !m_who);
            chk("lsu_respValid", lsu_respValid, m_act && m_done && m_who);
            chk("ifu_rdata", ifu_rdata, m_rd[0]);
            chk("lsu_rdata", lsu_rdata, m_rd[1]);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic mem_reply(input int delay, input logic [DW-1:0] rd);
        repeat (delay) tick();
        mem_respValid = 1'b1;
        mem_rdata     = rd;
        tick();
        mem_respValid = 1'b0;
    endtask

    bit  second_lsu;
    int  mem_cd;
    int  idle_cnt;
    int  n_done;

    initial begin
        repeat (2) tick();
        chk("rst_mem_reqValid", mem_reqValid, 1'b0);
        chk("rst_mem_fields", {mem_addr, mem_wdata}, 64'h0);
        chk("rst_mem_wen_wmask", {mem_wen, mem_wmask}, 5'h0);
        chk("rst_resp", {ifu_respValid, lsu_respValid}, 2'b00);
        chk("rst_rdata", {ifu_rdata, lsu_rdata}, 64'h0);
        rst_n    = 1'b1;
        model_on = 1;
        tick();

        // 1: IFU fetch, memory answers in the third BUSY cycle
        ifu_raddr = 32'h8000_0000; ifu_reqValid = 1'b1;
        tick();
        chk("t1_mem_reqValid", mem_reqValid, 1'b1);
        chk("t1_mem_addr", mem_addr, 32'h8000_0000);
        chk("t1_mem_wen", mem_wen, 1'b0);
        mem_reply(2, 32'h0010_0093);
        chk("t1_ifu_respValid", ifu_respValid, 1'b1);
        chk("t1_ifu_rdata", ifu_rdata, 32'h0010_0093);
        chk("t1_lsu_respValid", lsu_respValid, 1'b0);
        ifu_reqValid = 1'b0;
        tick();
        chk("t1_ifu_pulse_once", ifu_respValid, 1'b0);

        // 2: LSU write, fields stable through BUSY
        lsu_addr = 32'h8000_1004; lsu_wen = 1'b1; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011;
        lsu_reqValid = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("t2_mem_wen", mem_wen, 1'b1);
            chk("t2_mem_fields", {mem_addr, mem_wdata}, 64'h8000_1004_DEAD_BEEF);
            chk("t2_mem_wmask", mem_wmask, 4'b0011);
            if (i < 2) tick();
        end
        mem_reply(0, 32'h1234_5678);
        chk("t2_lsu_respValid", lsu_respValid, 1'b1);
        chk("t2_ifu_respValid", ifu_respValid, 1'b0);
        lsu_reqValid = 1'b0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
        tick();
        chk("t2_lsu_pulse_once", lsu_respValid, 1'b0);

        // 3: ties from reset (last_grant=IFU): LSU first in both modes, then mode-dependent
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        ifu_raddr = 32'h100; lsu_addr = 32'h200;
        ifu_reqValid = 1'b1; lsu_reqValid = 1'b1;
        tick();
        chk("t3_first_winner", mem_addr, 32'h200);
        mem_reply(0, 32'h11);
        chk("t3_first_lsu_resp", lsu_respValid, 1'b1);
        lsu_addr = 32'h204;
        tick();
        tick();
`ifdef ARB_RR_EN
        second_lsu = 0;
`else
        second_lsu = 1;
`endif
        chk("t3_second_winner", mem_addr, second_lsu ? 32'h204 : 32'h100);
        mem_reply(1, 32'h22);
        chk("t3_second_resp", {ifu_respValid, lsu_respValid}, second_lsu ? 2'b01 : 2'b10);
        if (second_lsu) lsu_reqValid = 1'b0; else ifu_reqValid = 1'b0;
        tick();
        tick();
        chk("t3_third_winner", mem_addr, second_lsu ? 32'h100 : 32'h204);
        mem_reply(0, 32'h33);
        ifu_reqValid = 1'b0; lsu_reqValid = 1'b0;
        tick();

        // 4: minimum latency, held request not re-granted
        ifu_raddr = 32'h300; ifu_reqValid = 1'b1;
        tick();
        chk("t4_cycle1_req", mem_reqValid, 1'b1);
        chk("t4_cycle1_noresp", ifu_respValid, 1'b0);
        mem_reply(0, 32'h44);
        chk("t4_cycle2_resp", ifu_respValid, 1'b1);
        chk("t4_cycle2_rdata", ifu_rdata, 32'h44);
        ifu_reqValid = 1'b0;
        tick();
        chk("t4_not_regranted", mem_reqValid, 1'b0);
        tick();
        chk("t4_still_idle", mem_reqValid, 1'b0);

        // 5: asynchronous reset while BUSY
        lsu_addr = 32'h400; lsu_reqValid = 1'b1;
        tick();
        chk("t5_busy", mem_reqValid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t5_async_req_drop", mem_reqValid, 1'b0);
        chk("t5_no_resp", {ifu_respValid, lsu_respValid}, 2'b00);
        chk("t5_rdata_cleared", {ifu_rdata, lsu_rdata}, 64'h0);
        lsu_reqValid = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        chk("t5_no_late_resp", {ifu_respValid, lsu_respValid}, 2'b00);
        ifu_raddr = 32'h500; lsu_addr = 32'h600;
        ifu_reqValid = 1'b1; lsu_reqValid = 1'b1;
        tick();
        chk("t5_last_grant_ifu", mem_addr, 32'h600);
        mem_reply(0, 32'h66);
        lsu_reqValid = 1'b0;
        tick();
        tick();
        mem_reply(0, 32'h55);
        ifu_reqValid = 1'b0;
        tick();

        // 6: spurious memory response in IDLE
        mem_respValid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        tick();
        mem_respValid = 1'b0;
        chk("t6_no_resp", {ifu_respValid, lsu_respValid}, 2'b00);
        chk("t6_no_req", mem_reqValid, 1'b0);
        chk("t6_rdata_kept", {ifu_rdata, lsu_rdata}, 64'h0000_0055_0000_0066);
        tick();

        // Random traffic: requester agents and a variable-latency memory
        mem_cd = -1; idle_cnt = 0; n_done = 0;
        for (int c = 0; c < 4000; c++) begin
            if (ifu_respValid || lsu_respValid) begin
                n_done++; idle_cnt = 0;
            end else begin
                idle_cnt++;
            end
            if (idle_cnt == 60) chk("progress_timeout", 1'b0, 1'b1);
            if (ifu_reqValid && ifu_respValid) ifu_reqValid = 1'b0;
            else if (!ifu_reqValid && $urandom_range(0, 2) == 0) begin
                ifu_raddr = $urandom; ifu_reqValid = 1'b1;
            end
            if (lsu_reqValid && lsu_respValid) lsu_reqValid = 1'b0;
            else if (!lsu_reqValid && $urandom_range(0, 2) == 0) begin
                lsu_addr = $urandom; lsu_wen = 1'($urandom);
                lsu_wdata = $urandom; lsu_wmask = 4'($urandom);
                lsu_reqValid = 1'b1;
            end
            mem_respValid = 1'b0;
            if (mem_reqValid) begin
                if (mem_cd < 0) mem_cd = $urandom_range(0, 3);
                if (mem_cd == 0) begin
                    mem_respValid = 1'b1; mem_rdata = $urandom; mem_cd = -1;
                end else begin
                    mem_cd--;
                end
            end else begin
                mem_cd = -1;
                if ($urandom_range(0, 7) == 0) begin
                    mem_respValid = 1'b1; mem_rdata = $urandom;
                end
            end
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0; mem_respValid = 1'b0;
                tick();
                rst_n = 1'b1; mem_cd = -1;
            end
            tick();
        end
        chk("random_completions", n_done > 200, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
